ddram_arb: RTL and testbench
============================

DDRAM_ARB -- requirements
Module: ddram_arb

Interface
REQ-001 Parameter RD_TIMEOUT, default 4096: maximum idle cycles between read beats before the read is abandoned.
REQ-002 clk_sys  in  1  sole clock; DDRAM_CLK and all logic run on it.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 rN_req  in  1  (N=0,1) request; held with fields stable until rN_ack.
REQ-005 rN_we  in  1  1 = single-beat write, 0 = burst read.
REQ-006 rN_addr  in  29  64-bit word address.
REQ-007 rN_burst  in  8  read beat count; 0 treated as 1; ignored for writes (always 1).
REQ-008 rN_din  in  64  write data.
REQ-009 rN_be  in  8  write byte enables.
REQ-010 rN_ack  out  1  one-cycle pulse: command accepted by DDRAM.
REQ-011 rN_rvalid  out  1  read beat valid for requester N.
REQ-012 rN_rlast  out  1  with rvalid, marks final beat.
REQ-013 rN_err  out  1  one-cycle pulse: read timed out.
REQ-014 rdata  out  64  read data shared by both requesters, qualified by rN_rvalid.
REQ-015 DDRAM_CLK out 1; DDRAM_BUSY in 1; DDRAM_BURSTCNT out 8; DDRAM_ADDR out 29; DDRAM_DOUT in 64; DDRAM_DOUT_READY in 1; DDRAM_RD out 1; DDRAM_DIN out 64; DDRAM_BE out 8; DDRAM_WE out 1 -- MiSTer DDRAM port, BUSY = wait-request.

Function
REQ-016 DDRAM_CLK SHALL equal clk_sys; all other outputs registered.
REQ-017 States: IDLE, CMD, RDATA.
REQ-018 IDLE: any rN_req -> latch winner's fields into DDRAM_* registers, assert DDRAM_RD or DDRAM_WE next cycle, go CMD.
REQ-019 Both requests in same IDLE cycle: grant the requester not granted last; after reset r0 wins first tie.
REQ-020 CMD: hold RD/WE, ADDR, BURSTCNT, DIN, BE stable while DDRAM_BUSY=1; on cycle with BUSY=0 the command is accepted.
REQ-021 Acceptance: drop RD/WE next cycle, pulse owner's rN_ack next cycle; write -> IDLE, read -> RDATA with beat counter = burst (0->1).
REQ-022 RDATA: each DDRAM_DOUT_READY -> rdata=DDRAM_DOUT and owner rvalid one cycle later; counter decrements; rlast on final beat; -> IDLE after final beat.
REQ-023 Non-owner rvalid/rlast/ack/err SHALL never assert.
REQ-024 RDATA: RD_TIMEOUT consecutive cycles without DOUT_READY -> pulse owner rN_err, -> IDLE; later stray beats ignored.
REQ-025 DOUT_READY outside RDATA SHALL be ignored.
REQ-026 rN_req dropped during CMD/RDATA: transaction still completes; new request only sampled in IDLE.
REQ-027 Minimum IDLE-to-IDLE for write with BUSY=0: 3 cycles (IDLE, CMD, IDLE); back-to-back grants alternate when both requesters hold req.

Reset
REQ-028 reset_n low: state IDLE, DDRAM_RD/WE=0, DDRAM_ADDR/BURSTCNT/DIN/BE=0, all rN_ack/rvalid/rlast/err=0, rdata=0, counters 0, last-grant=r1.
REQ-029 Reset mid-CMD or mid-RDATA SHALL abandon the transaction without ack/err pulses.

Structure
REQ-030 Package ddram_arb_pkg: state enum, ADDR_W=29, DATA_W=64, BE_W=8, BURST_W=8.
REQ-031 Sub-module ddram_arb_rr: 2-way round-robin picker (req[1:0], last-grant in; grant out).

Verification
REQ-032 r0 write addr 0x100, be 0xFF, BUSY=0 -> WE one cycle, r0_ack one cycle later, back to IDLE.
REQ-033 r1 read burst 4, BUSY high 5 cycles -> RD held 6 cycles with stable ADDR/BURSTCNT=4; 4 DOUT beats -> 4 r1_rvalid, rlast on 4th.
REQ-034 r0 and r1 both request continuously -> grants r0,r1,r0,r1; no ack on non-owner.
REQ-035 Read burst 2, one beat then silence, RD_TIMEOUT=16 -> r_err pulse 16 cycles after beat, IDLE, later beat ignored.
REQ-036 reset_n low during RDATA after 1 of 8 beats -> all outputs zero, IDLE, no rvalid for remaining beats.
REQ-037 rN_burst=0 read -> DDRAM_BURSTCNT=1, single beat with rlast.

Source files
------------

// File: rtl/ddram_arb_pkg.sv
// Shared types and widths for the two-requester MiSTer DDRAM arbiter.
package ddram_arb_pkg;

  localparam int unsigned ADDR_W  = 29;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned BE_W    = 8;
  localparam int unsigned BURST_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_RDATA = 2'd2
  } state_e;

  typedef struct packed {
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [BURST_W-1:0] burst;
    logic [DATA_W-1:0]  din;
    logic [BE_W-1:0]    be;
  } cmd_t;

  // Beat count actually issued: writes are single-beat, a zero read burst means one beat.
  function automatic logic [BURST_W-1:0] eff_burst(input logic we, input logic [BURST_W-1:0] burst);
    if (we || (burst == '0)) return BURST_W'(1);
    return burst;
  endfunction

endpackage

// File: rtl/ddram_arb_rr.sv
// Two-way round-robin picker: on a tie, grant the requester that did not win last.
module ddram_arb_rr (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant_c
);

  always_comb begin
    o_grant_c = 2'b00;
    if (i_req == 2'b11) o_grant_c = i_last ? 2'b01 : 2'b10;
    else                o_grant_c = i_req;
  end

endmodule

// File: rtl/ddram_arb.sv
// Arbitrates two requesters onto one MiSTer DDRAM port: single-beat writes and
// burst reads, with round-robin grant and an inter-beat read timeout.
module ddram_arb
  import ddram_arb_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = 4096
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic                r0_req,
  input  logic                r0_we,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic [BURST_W-1:0]  r0_burst,
  input  logic [DATA_W-1:0]   r0_din,
  input  logic [BE_W-1:0]     r0_be,
  output logic                r0_ack,
  output logic                r0_rvalid,
  output logic                r0_rlast,
  output logic                r0_err,
  input  logic                r1_req,
  input  logic                r1_we,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic [BURST_W-1:0]  r1_burst,
  input  logic [DATA_W-1:0]   r1_din,
  input  logic [BE_W-1:0]     r1_be,
  output logic                r1_ack,
  output logic                r1_rvalid,
  output logic                r1_rlast,
  output logic                r1_err,
  output logic [DATA_W-1:0]   rdata,
  output logic                DDRAM_CLK,
  input  logic                DDRAM_BUSY,
  output logic [BURST_W-1:0]  DDRAM_BURSTCNT,
  output logic [ADDR_W-1:0]   DDRAM_ADDR,
  input  logic [DATA_W-1:0]   DDRAM_DOUT,
  input  logic                DDRAM_DOUT_READY,
  output logic                DDRAM_RD,
  output logic [DATA_W-1:0]   DDRAM_DIN,
  output logic [BE_W-1:0]     DDRAM_BE,
  output logic                DDRAM_WE
);

  localparam int unsigned TMR_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  state_e              r_state, w_state_nxt;
  cmd_t                r_cmd, w_cmd_nxt;
  logic                r_rd, w_rd_nxt;
  logic                r_we, w_we_nxt;
  logic                r_owner, w_owner_nxt;
  logic                r_last, w_last_nxt;
  logic [BURST_W-1:0]  r_cnt, w_cnt_nxt;
  logic [TMR_W-1:0]    r_tmr, w_tmr_nxt;
  logic [1:0]          r_ack, w_ack_nxt;
  logic [1:0]          r_rvalid, w_rvalid_nxt;
  logic [1:0]          r_rlast, w_rlast_nxt;
  logic [1:0]          r_err, w_err_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;

  logic [1:0]          w_req;
  logic [1:0]          w_grant_c;
  logic [1:0]          w_owner_oh;
  cmd_t                w_r0_cmd, w_r1_cmd, w_sel;

  // A requester still sees its ack this cycle and may not have dropped req yet.
  assign w_req      = {r1_req & ~r_ack[1], r0_req & ~r_ack[0]};
  assign w_owner_oh = r_owner ? 2'b10 : 2'b01;
  assign w_r0_cmd   = '{we: r0_we, addr: r0_addr, burst: eff_burst(r0_we, r0_burst), din: r0_din, be: r0_be};
  assign w_r1_cmd   = '{we: r1_we, addr: r1_addr, burst: eff_burst(r1_we, r1_burst), din: r1_din, be: r1_be};
  assign w_sel      = w_grant_c[1] ? w_r1_cmd : w_r0_cmd;

  ddram_arb_rr u_rr (
    .i_req     (w_req),
    .i_last    (r_last),
    .o_grant_c (w_grant_c)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cmd    <= '0;
      r_rd     <= 1'b0;
      r_we     <= 1'b0;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_cnt    <= '0;
      r_tmr    <= '0;
      r_ack    <= '0;
      r_rvalid <= '0;
      r_rlast  <= '0;
      r_err    <= '0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cmd    <= w_cmd_nxt;
      r_rd     <= w_rd_nxt;
      r_we     <= w_we_nxt;
      r_owner  <= w_owner_nxt;
      r_last   <= w_last_nxt;
      r_cnt    <= w_cnt_nxt;
      r_tmr    <= w_tmr_nxt;
      r_ack    <= w_ack_nxt;
      r_rvalid <= w_rvalid_nxt;
      r_rlast  <= w_rlast_nxt;
      r_err    <= w_err_nxt;
      r_rdata  <= w_rdata_nxt;
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_nxt    = r_cmd;
    w_rd_nxt     = r_rd;
    w_we_nxt     = r_we;
    w_owner_nxt  = r_owner;
    w_last_nxt   = r_last;
    w_cnt_nxt    = r_cnt;
    w_tmr_nxt    = r_tmr;
    w_ack_nxt    = '0;
    w_rvalid_nxt = '0;
    w_rlast_nxt  = '0;
    w_err_nxt    = '0;
    w_rdata_nxt  = r_rdata;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_owner_nxt = w_grant_c[1];
          w_last_nxt  = w_grant_c[1];
          w_cmd_nxt   = w_sel;
          w_rd_nxt    = ~w_sel.we;
          w_we_nxt    = w_sel.we;
          w_state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        if (!DDRAM_BUSY) begin
          w_rd_nxt  = 1'b0;
          w_we_nxt  = 1'b0;
          w_ack_nxt = w_owner_oh;
          if (r_we) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_RDATA;
            w_cnt_nxt   = r_cmd.burst;
            w_tmr_nxt   = '0;
          end
        end
      end
      ST_RDATA: begin
        if (DDRAM_DOUT_READY) begin
          w_rdata_nxt  = DDRAM_DOUT;
          w_rvalid_nxt = w_owner_oh;
          w_tmr_nxt    = '0;
          w_cnt_nxt    = r_cnt - BURST_W'(1);
          if (r_cnt == BURST_W'(1)) begin
            w_rlast_nxt = w_owner_oh;
            w_state_nxt = ST_IDLE;
          end
        end else if (r_tmr == TMR_W'(RD_TIMEOUT - 1)) begin
          w_err_nxt   = w_owner_oh;
          w_tmr_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmr_nxt = r_tmr + TMR_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign DDRAM_CLK      = clk_sys;
  assign DDRAM_RD       = r_rd;
  assign DDRAM_WE       = r_we;
  assign DDRAM_ADDR     = r_cmd.addr;
  assign DDRAM_BURSTCNT = r_cmd.burst;
  assign DDRAM_DIN      = r_cmd.din;
  assign DDRAM_BE       = r_cmd.be;
  assign rdata          = r_rdata;
  assign r0_ack         = r_ack[0];
  assign r1_ack         = r_ack[1];
  assign r0_rvalid      = r_rvalid[0];
  assign r1_rvalid      = r_rvalid[1];
  assign r0_rlast       = r_rlast[0];
  assign r1_rlast       = r_rlast[1];
  assign r0_err         = r_err[0];
  assign r1_err         = r_err[1];

endmodule

// File: tb/tb_ddram_arb.sv
// Bench for ddram_arb: directed timing cases, then random traffic against a memory/scoreboard model.
module tb_ddram_arb;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [1:0]  req, we;
  logic [28:0] addr [2];
  logic [7:0]  burst [2];
  logic [63:0] din [2];
  logic [7:0]  be [2];
  logic        r0_ack, r0_rvalid, r0_rlast, r0_err;
  logic        r1_ack, r1_rvalid, r1_rlast, r1_err;
  logic [63:0] rdata;
  logic        DDRAM_CLK, busy, dout_ready;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] dout, DDRAM_DIN;
  logic        DDRAM_RD, DDRAM_WE;
  logic [7:0]  DDRAM_BE;
  logic [1:0]  acks, rvs, rls, errs;

  assign acks = {r1_ack, r0_ack};
  assign rvs  = {r1_rvalid, r0_rvalid};
  assign rls  = {r1_rlast, r0_rlast};
  assign errs = {r1_err, r0_err};

  always #5 clk_sys = ~clk_sys;

  ddram_arb #(.RD_TIMEOUT(16)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .r0_req(req[0]), .r0_we(we[0]), .r0_addr(addr[0]), .r0_burst(burst[0]),
    .r0_din(din[0]), .r0_be(be[0]), .r0_ack(r0_ack), .r0_rvalid(r0_rvalid),
    .r0_rlast(r0_rlast), .r0_err(r0_err),
    .r1_req(req[1]), .r1_we(we[1]), .r1_addr(addr[1]), .r1_burst(burst[1]),
    .r1_din(din[1]), .r1_be(be[1]), .r1_ack(r1_ack), .r1_rvalid(r1_rvalid),
    .r1_rlast(r1_rlast), .r1_err(r1_err),
    .rdata(rdata), .DDRAM_CLK(DDRAM_CLK), .DDRAM_BUSY(busy),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_DOUT(dout),
    .DDRAM_DOUT_READY(dout_ready), .DDRAM_RD(DDRAM_RD), .DDRAM_DIN(DDRAM_DIN),
    .DDRAM_BE(DDRAM_BE), .DDRAM_WE(DDRAM_WE)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          owner;
    logic [63:0] data;
    bit          last;
  } beat_t;

  bit [63:0]   ref_mem [bit [28:0]];
  bit [63:0]   slv_mem [bit [28:0]];
  beat_t       exp_q [$];
  logic [63:0] beat_q [$];

  function automatic logic [63:0] mem_init(input logic [28:0] a);
    return {32'hA5A5_5A5A, 3'b000, a};
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] b);
    logic [63:0] r = old;
    for (int i = 0; i < 8; i++) if (b[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ref_rd(input logic [28:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  function automatic logic [63:0] slv_rd(input logic [28:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : mem_init(a);
  endfunction

  task automatic tick();
    @(negedge clk_sys);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_cmd"}, 64'({DDRAM_RD, DDRAM_WE, DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_BE}), 64'(0));
    check_eq({tag, "_din"}, DDRAM_DIN, 64'(0));
    check_eq({tag, "_rdata"}, rdata, 64'(0));
    check_eq({tag, "_flags"}, 64'({acks, rvs, rls, errs}), 64'(0));
  endtask

  // Both requesters hold write requests; acks must alternate starting with r0.
  task automatic rr_run(input string tag, input int nacks);
    int got = 0;
    req = 2'b11; we = 2'b11; addr[0] = 29'h10; addr[1] = 29'h20; busy = 1'b0;
    for (int c = 0; c < 8 * nacks && got < nacks; c++) begin
      tick();
      if (DDRAM_WE) check_eq($sformatf("%s_addr%0d", tag, got), 64'(DDRAM_ADDR), 64'((got % 2) ? 29'h20 : 29'h10));
      if (acks != 2'b00) begin
        check_eq($sformatf("%s_ack%0d", tag, got), 64'(acks), 64'((got % 2) ? 2'b10 : 2'b01));
        got++;
      end
    end
    req = 2'b00;
    check_eq({tag, "_count"}, 64'(got), 64'(nacks));
  endtask

  initial begin
    int    left [2];
    int    wt [2];
    int    done_tx, gap, o, nexp;
    bit    pend, finished;
    logic        cap_we;
    logic [28:0] cap_addr;
    logic [7:0]  cap_burst, cap_be;
    logic [63:0] cap_din;
    beat_t       e;

    reset_n = 1'b0; req = '0; we = '0; busy = 1'b0; dout_ready = 1'b0; dout = '0;
    for (int n = 0; n < 2; n++) begin addr[n] = '0; burst[n] = '0; din[n] = '0; be[n] = '0; end
    tick(); tick();
    check_all_zero("reset");
    check_eq("ddram_clk", 64'(DDRAM_CLK), 64'(clk_sys));
    reset_n = 1'b1;
    tick();

    // Single write, no wait-request.
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 29'h100; be[0] = 8'hFF; din[0] = 64'h1122_3344_5566_7788; burst[0] = 8'd7;
    tick();
    check_eq("wr_we", 64'({DDRAM_WE, DDRAM_RD}), 64'(2'b10));
    check_eq("wr_addr", 64'(DDRAM_ADDR), 64'(29'h100));
    check_eq("wr_be_cnt", 64'({DDRAM_BE, DDRAM_BURSTCNT}), 64'(16'hFF01));
    check_eq("wr_din", DDRAM_DIN, 64'h1122_3344_5566_7788);
    check_eq("wr_noack_yet", 64'(acks), 64'(0));
    tick();
    check_eq("wr_we_drop", 64'(DDRAM_WE), 64'(0));
    check_eq("wr_ack", 64'(acks), 64'(2'b01));
    req[0] = 1'b0;
    tick();
    check_eq("wr_ack_pulse", 64'(acks), 64'(0));

    // r1 burst-4 read held off by 5 busy cycles.
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 29'h123_4567; burst[1] = 8'd4; busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq($sformatf("rd_hold%0d", i), 64'({DDRAM_RD, DDRAM_ADDR, DDRAM_BURSTCNT, acks}),
               64'({1'b1, 29'h123_4567, 8'd4, 2'b00}));
      if (i == 5) busy = 1'b0;
    end
    tick();
    check_eq("rd_accept", 64'({DDRAM_RD, acks}), 64'(3'b010));
    req[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        tick();
        check_eq("rd_gap", 64'(rvs), 64'(0));
      end
      dout_ready = 1'b1; dout = 64'hBEEF_0000_0000_0000 + 64'(k);
      tick();
      dout_ready = 1'b0;
      check_eq($sformatf("rd_beat%0d_flags", k), 64'({rvs, rls}), 64'({2'b10, (k == 3) ? 2'b10 : 2'b00}));
      check_eq($sformatf("rd_beat%0d_data", k), rdata, 64'hBEEF_0000_0000_0000 + 64'(k));
    end
    tick();
    check_eq("rd_after", 64'(rvs), 64'(0));

    rr_run("rr", 4);

    // Burst 0 read is a single beat.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 29'h55; burst[0] = 8'd0;
    tick();
    check_eq("b0_cmd", 64'({DDRAM_RD, DDRAM_BURSTCNT}), 64'({1'b1, 8'd1}));
    tick();
    check_eq("b0_ack", 64'(acks), 64'(2'b01));
    req[0] = 1'b0; dout_ready = 1'b1; dout = 64'hCAFE;
    tick();
    dout_ready = 1'b0;
    check_eq("b0_beat", 64'({rvs, rls}), 64'(4'b0101));
    check_eq("b0_data", rdata, 64'hCAFE);
    tick();
    check_eq("b0_after", 64'(rvs), 64'(0));

    // Read timeout: one beat of two, then silence.
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 29'h77; burst[1] = 8'd2;
    tick();
    check_eq("to_rd", 64'(DDRAM_RD), 64'(1));
    tick();
    check_eq("to_ack", 64'(acks), 64'(2'b10));
    req[1] = 1'b0; dout_ready = 1'b1; dout = 64'h1234;
    tick();
    dout_ready = 1'b0;
    check_eq("to_beat", 64'({rvs, rls}), 64'(4'b1000));
    for (int i = 1; i <= 16; i++) begin
      tick();
      check_eq($sformatf("to_err_c%0d", i), 64'({errs, rvs}), 64'({(i == 16) ? 2'b10 : 2'b00, 2'b00}));
    end
    dout_ready = 1'b1; dout = 64'h9999;
    tick();
    dout_ready = 1'b0;
    check_eq("to_stray", 64'({rvs, errs}), 64'(0));

    // Reset in the middle of an 8-beat read.
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 29'h99; burst[0] = 8'd8;
    tick(); tick();
    check_eq("mr_ack", 64'(acks), 64'(2'b01));
    req[0] = 1'b0; dout_ready = 1'b1; dout = 64'h4444;
    tick();
    check_eq("mr_beat", 64'(rvs), 64'(2'b01));
    reset_n = 1'b0;
    #1;
    check_all_zero("mr_reset");
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      dout = 64'(i);
      tick();
      check_eq($sformatf("mr_nobeat%0d", i), 64'({rvs, rls, errs, acks}), 64'(0));
    end
    dout_ready = 1'b0;
    rr_run("rr_post_reset", 2);
    tick();

    // Random traffic against memory model and scoreboard.
    left = '{20, 20}; wt = '{0, 0}; done_tx = 0; gap = 0; pend = 1'b0; finished = 1'b0;
    cap_we = 1'b0; cap_addr = '0; cap_burst = '0; cap_be = '0; cap_din = '0;
    for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
      tick();
      if (pend) begin
        check_eq("rnd_ack_onehot", 64'((acks == 2'b01) || (acks == 2'b10)), 64'(1));
        if ((acks == 2'b01) || (acks == 2'b10)) begin
          o = int'(r1_ack);
          nexp = (we[o] || burst[o] == 8'd0) ? 1 : int'(burst[o]);
          check_eq("rnd_we", 64'(cap_we), 64'(we[o]));
          check_eq("rnd_addr", 64'(cap_addr), 64'(addr[o]));
          check_eq("rnd_bcnt", 64'(cap_burst), 64'(nexp));
          if (we[o]) begin
            check_eq("rnd_din", cap_din, din[o]);
            check_eq("rnd_be", 64'(cap_be), 64'(be[o]));
            ref_mem[addr[o]] = merge(ref_rd(addr[o]), din[o], be[o]);
            slv_mem[cap_addr] = merge(slv_rd(cap_addr), cap_din, cap_be);
          end else begin
            for (int k = 0; k < nexp; k++)
              exp_q.push_back('{owner: o[0], data: ref_rd(29'(addr[o] + 29'(k))), last: (k == nexp - 1)});
            for (int k = 0; k < int'(cap_burst); k++)
              beat_q.push_back(slv_rd(29'(cap_addr + 29'(k))));
            gap = 0;
          end
          req[o] = 1'b0;
          wt[o] = int'($urandom_range(0, 3));
          done_tx++;
        end
        pend = 1'b0;
      end else begin
        check_eq("rnd_no_ack", 64'(acks), 64'(0));
      end
      check_eq("rnd_no_err", 64'(errs), 64'(0));
      if (rvs != 2'b00) begin
        if (exp_q.size() == 0) begin
          check_eq("rnd_extra_beat", 64'(rvs), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check_eq("rnd_rv_owner", 64'(rvs), 64'(e.owner ? 2'b10 : 2'b01));
          check_eq("rnd_rdata", rdata, e.data);
          check_eq("rnd_rlast", 64'(rls), 64'(e.last ? (e.owner ? 2'b10 : 2'b01) : 2'b00));
        end
      end else begin
        check_eq("rnd_rlast_idle", 64'(rls), 64'(0));
      end
      if (DDRAM_RD || DDRAM_WE) begin
        busy = ($urandom_range(0, 2) == 0);
        if (!busy) begin
          pend = 1'b1;
          cap_we = DDRAM_WE; cap_addr = DDRAM_ADDR; cap_burst = DDRAM_BURSTCNT;
          cap_din = DDRAM_DIN; cap_be = DDRAM_BE;
        end
      end else begin
        busy = ($urandom_range(0, 3) == 0);
      end
      if (beat_q.size() > 0 && (gap >= 3 || $urandom_range(0, 1) == 0)) begin
        dout_ready = 1'b1; dout = beat_q.pop_front(); gap = 0;
      end else begin
        if (beat_q.size() > 0) gap++;
        dout_ready = (beat_q.size() == 0) && ($urandom_range(0, 19) == 0);
        dout = {$urandom, $urandom};
      end
      for (int n = 0; n < 2; n++) begin
        if (!req[n] && left[n] > 0) begin
          if (wt[n] > 0) wt[n]--;
          else begin
            req[n] = 1'b1; we[n] = 1'($urandom_range(0, 1)); addr[n] = 29'($urandom_range(0, 15));
            burst[n] = 8'($urandom_range(0, 4)); din[n] = {$urandom, $urandom}; be[n] = 8'($urandom);
            left[n]--;
          end
        end
      end
      finished = (left[0] == 0) && (left[1] == 0) && (req == 2'b00) && !pend &&
                 (exp_q.size() == 0) && (beat_q.size() == 0);
    end
    dout_ready = 1'b0;
    check_eq("rnd_tx_done", 64'(done_tx), 64'(40));
    check_eq("rnd_drain", 64'(exp_q.size()), 64'(0));
    tick(); tick();
    check_eq("rnd_quiet", 64'({rvs, acks, errs, DDRAM_RD, DDRAM_WE}), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
